// File: rtl/candidate_bias_adder_if.sv
// Stream and bias-memory signals of the candidate bias adder.
// The slave modport is the adder's view; the master modport is its environment.
interface candidate_bias_adder_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 7,
    parameter int ACC_WIDTH  = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [ACC_WIDTH-1:0]  in_data;
    logic                  bias_read_enable;
    logic [ADDR_WIDTH-1:0] bias_pointer;
    logic [DATA_WIDTH-1:0] bias_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH-1:0] out_index;

    modport slave (
        input  in_valid, in_data, bias_data, out_ready,
        output in_ready, bias_read_enable, bias_pointer, out_valid, out_data, out_index
    );

    modport master (
        output in_valid, in_data, bias_data, out_ready,
        input  in_ready, bias_read_enable, bias_pointer, out_valid, out_data, out_index
    );
endinterface

// File: rtl/candidate_bias_adder.sv
// Adds a per-unit candidate bias to each pre-activation sum and saturates it
// to DATA_WIDTH, walking units 0..NUM_UNITS-1 once per start pulse.
//
// state  | meaning
// IDLE   | waiting for start, busy low
// FETCH  | one-cycle read strobe to bias memory at idx
// LOAD   | bias memory output captured into bias_reg
// ACCEPT | in_ready high, waiting for the pre-activation sum
// EMIT   | out_valid high, holding the result until downstream accepts
module candidate_bias_adder #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 7,
    parameter int ACC_WIDTH  = 32,
    parameter int NUM_UNITS  = 100
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    candidate_bias_adder_if.slave  bus,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, ACCEPT, EMIT} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_UNITS - 1);
    localparam logic signed [ACC_WIDTH:0] SAT_MAX =
        $signed({{(ACC_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}});
    localparam logic signed [ACC_WIDTH:0] SAT_MIN = ~SAT_MAX;
    localparam logic [DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] OUT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    state_t                   state, state_nxt;
    logic [ADDR_WIDTH-1:0]    idx;
    logic signed [DATA_WIDTH-1:0] bias_reg;
    logic [DATA_WIDTH-1:0]    out_data_r;
    logic signed [ACC_WIDTH:0] sum_ext;
    logic [DATA_WIDTH-1:0]    sum_sat;
    logic                     last_unit;
    logic                     in_fire;
    logic                     out_fire;

    assign last_unit = (idx == LAST_IDX);
    assign in_fire   = (state == ACCEPT) && bus.in_valid;
    assign out_fire  = (state == EMIT) && bus.out_ready;

    // One extra bit of headroom so the add itself can never wrap before saturation.
    assign sum_ext = (ACC_WIDTH+1)'($signed(bus.in_data)) + (ACC_WIDTH+1)'(bias_reg);

    always_comb begin
        if (sum_ext > SAT_MAX) begin
            sum_sat = OUT_MAX;
        end else if (sum_ext < SAT_MIN) begin
            sum_sat = OUT_MIN;
        end else begin
            sum_sat = sum_ext[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt            = state;
        busy                 = 1'b1;
        done                 = 1'b0;
        bus.in_ready         = 1'b0;
        bus.bias_read_enable = 1'b0;
        bus.out_valid        = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = FETCH;
            end
            FETCH: begin
                bus.bias_read_enable = 1'b1;
                state_nxt            = LOAD;
            end
            LOAD: begin
                state_nxt = ACCEPT;
            end
            ACCEPT: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nxt = EMIT;
            end
            EMIT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    done      = last_unit;
                    state_nxt = last_unit ? IDLE : FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // idx only moves on the way into FETCH, so it doubles as a stable bias_pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            bias_reg   <= '0;
            out_data_r <= '0;
        end else begin
            if ((state == IDLE) && start) begin
                idx <= '0;
            end else if (out_fire && !last_unit) begin
                idx <= idx + 1'b1;
            end
            if (state == LOAD) bias_reg <= bus.bias_data;
            if (in_fire) out_data_r <= sum_sat;
        end
    end

    assign bus.bias_pointer = idx;
    assign bus.out_index    = idx;
    assign bus.out_data     = out_data_r;

endmodule

// File: tb/tb_candidate_bias_adder.sv
// Scoreboard bench for candidate_bias_adder with a registered bias memory model
// that drives random data on every cycle it is not being read.
module tb_candidate_bias_adder;

    localparam int DW  = 16;
    localparam int AW  = 7;
    localparam int ACW = 32;
    localparam int NU  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic busy, done;

    candidate_bias_adder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ACC_WIDTH(ACW)) bus ();

    candidate_bias_adder #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ACC_WIDTH(ACW), .NUM_UNITS(NU)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bus   (bus.slave),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0]  bias_mem [NU];
    logic [ACW-1:0] din [NU];

    always @(posedge clk)
        bus.bias_data <= bus.bias_read_enable ? bias_mem[int'(bus.bias_pointer)] : DW'($urandom);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] sat_model(input logic [ACW-1:0] a, input logic [DW-1:0] b);
        longint s;
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (DW-1)) - 1;
        lo = -(longint'(1) <<< (DW-1));
        s  = longint'($signed(a)) + longint'($signed(b));
        if (s > hi) return {1'b0, {(DW-1){1'b1}}};
        if (s < lo) return {1'b1, {(DW-1){1'b0}}};
        return s[DW-1:0];
    endfunction

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] index;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int unit_ctr = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    int cyc = 0;
    int t_start = 0;
    int last_pass_cycles = 0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            unit_ctr = 0;
        end else begin
            if (start && !busy) begin
                unit_ctr = 0;
                t_start  = cyc;
            end
            if (bus.bias_read_enable) begin
                rd_cnt++;
                chk("bias_pointer", 64'(bus.bias_pointer), 64'(unit_ctr));
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back('{data: sat_model(bus.in_data, bias_mem[unit_ctr]),
                                  index: AW'(unit_ctr)});
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_out", 64'(bus.out_valid), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", 64'(bus.out_data), 64'(e.data));
                    chk("out_index", 64'(bus.out_index), 64'(e.index));
                    chk("done_at_handoff", 64'(done), 64'(e.index == AW'(NU-1)));
                end
                unit_ctr++;
            end else if (done) begin
                chk("done_spurious", 64'(done), 64'(0));
            end
            if (done) begin
                done_cnt++;
                last_pass_cycles = cyc - t_start;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input logic [ACW-1:0] d, input int stall);
        int n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("in_ready_timeout", 64'(bus.in_ready), 64'(1));
        for (int s = 0; s < stall; s++) begin
            chk("stall_in_ready", 64'(bus.in_ready), 64'(1));
            chk("stall_out_valid", 64'(bus.out_valid), 64'(0));
            start = (s == 1);
            tick();
        end
        start        = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        chk("pass_timeout_busy", 64'(busy), 64'(0));
    endtask

    task automatic run_pass(input int stall_unit);
        pulse_start();
        for (int u = 0; u < NU; u++) feed(din[u], (u == stall_unit) ? 4 : 0);
        wait_idle();
    endtask

    task automatic pass_end(input string tag, input int rd0, input int dn0);
        chk({tag, "_reads"}, 64'(rd_cnt - rd0), 64'(NU));
        chk({tag, "_done_count"}, 64'(done_cnt - dn0), 64'(1));
        chk({tag, "_sb_drained"}, 64'(exp_q.size()), 64'(0));
    endtask

    int rd0, dn0;
    logic [DW-1:0] held;

    initial begin
        #2000000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        bias_mem = '{16'h0100, 16'hFF00, 16'h0010};
        #1 rst_n = 1'b0;
        #2;
        chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
        chk("rst_rd_en", 64'(bus.bias_read_enable), 64'(0));
        chk("rst_pointer", 64'(bus.bias_pointer), 64'(0));
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_out_data", 64'(bus.out_data), 64'(0));
        chk("rst_out_index", 64'(bus.out_index), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        #9 rst_n = 1'b1;
        tick();

        // nominal pass, zero-wait handshakes
        din = '{32'h200, 32'h100, 32'd5};
        rd0 = rd_cnt; dn0 = done_cnt;
        run_pass(-1);
        pass_end("nominal", rd0, dn0);
        chk("nominal_cycles", 64'(last_pass_cycles), 64'(4*NU));

        // saturation both ways, plus a sum that would wrap at ACC_WIDTH bits
        bias_mem = '{16'h7000, 16'h8000, 16'h7000};
        din = '{32'h00002000, 32'hFFFFF000, 32'h7FFFFFFF};
        rd0 = rd_cnt; dn0 = done_cnt;
        run_pass(-1);
        pass_end("saturate", rd0, dn0);

        // input stall on unit 1 with a start pulse while busy
        bias_mem = '{16'h0001, 16'hFFFF, 16'h8000};
        din = '{32'hFFFF8000, 32'h00007FFF, 32'h80000000};
        rd0 = rd_cnt; dn0 = done_cnt;
        run_pass(1);
        pass_end("stall", rd0, dn0);

        // output backpressure on unit 0
        bias_mem = '{16'h0100, 16'hFF00, 16'h0010};
        din = '{32'h1234, 32'h1, 32'h2};
        rd0 = rd_cnt; dn0 = done_cnt;
        pulse_start();
        feed(din[0], 0);
        bus.out_ready = 1'b0;
        held = sat_model(din[0], bias_mem[0]);
        for (int k = 0; k < 5; k++) begin
            chk("bp_out_valid", 64'(bus.out_valid), 64'(1));
            chk("bp_out_data", 64'(bus.out_data), 64'(held));
            chk("bp_out_index", 64'(bus.out_index), 64'(0));
            chk("bp_rd_en", 64'(bus.bias_read_enable), 64'(0));
            chk("bp_in_ready", 64'(bus.in_ready), 64'(0));
            tick();
        end
        bus.out_ready = 1'b1;
        feed(din[1], 0);
        feed(din[2], 0);
        wait_idle();
        pass_end("backpressure", rd0, dn0);

        // reset during unit 1 EMIT
        din = '{32'h1, 32'h50, 32'h2};
        dn0 = done_cnt;
        pulse_start();
        feed(din[0], 0);
        feed(din[1], 0);
        bus.out_ready = 1'b0;
        tick();
        chk("pre_rst_out_valid", 64'(bus.out_valid), 64'(1));
        chk("pre_rst_out_data", 64'(bus.out_data), 64'(sat_model(din[1], bias_mem[1])));
        chk("pre_rst_out_index", 64'(bus.out_index), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("midrst_out_data", 64'(bus.out_data), 64'(0));
        chk("midrst_out_index", 64'(bus.out_index), 64'(0));
        chk("midrst_pointer", 64'(bus.bias_pointer), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_done", 64'(done), 64'(0));
        #3 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        chk("midrst_no_done", 64'(done_cnt - dn0), 64'(0));
        din = '{32'h7, 32'h8, 32'h9};
        rd0 = rd_cnt; dn0 = done_cnt;
        run_pass(-1);
        pass_end("after_reset", rd0, dn0);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
